// File: rtl/operand_sequencer_pkg.sv
// Shared fixed-point definitions for the operand sequencer: default word
// geometry, row-select codes and FSM state encoding.
package operand_sequencer_pkg;

  localparam int unsigned DEF_INT_LENGTH  = 5;
  localparam int unsigned DEF_FRAC_LENGTH = 12;

  localparam logic [1:0] SEL_ROW0 = 2'b00;
  localparam logic [1:0] SEL_ROW1 = 2'b01;
  localparam logic [1:0] SEL_ROW2 = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW0 = 2'd1,
    ROW1 = 2'd2,
    ROW2 = 2'd3
  } state_t;

endpackage

// File: rtl/operand_sequencer_mux3x1.sv
// Three-way word selector driven by a row-select code; SEL_NONE yields zero.
module mux3x1
  import operand_sequencer_pkg::*;
#(
  parameter int unsigned W = DEF_INT_LENGTH + DEF_FRAC_LENGTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      SEL_ROW0: y = a;
      SEL_ROW1: y = b;
      SEL_ROW2: y = c;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/operand_sequencer.sv
// Accepts one matrix column (three rows) per handshake and serializes it onto
// a single-element output stream, tagging row, column and frame boundaries.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int unsigned INT_LENGTH  = DEF_INT_LENGTH,
  parameter int unsigned FRAC_LENGTH = DEF_FRAC_LENGTH,
  parameter int unsigned N_COLS      = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [INT_LENGTH+FRAC_LENGTH-1:0] in_a,
  input  logic [INT_LENGTH+FRAC_LENGTH-1:0] in_b,
  input  logic [INT_LENGTH+FRAC_LENGTH-1:0] in_c,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [INT_LENGTH+FRAC_LENGTH-1:0] out_data,
  output logic [1:0]                        out_sel,
  output logic                              out_last,
  output logic [1:0]                        out_col,
  output logic                              out_frame_end
);

  localparam int unsigned W = INT_LENGTH + FRAC_LENGTH;
  localparam logic [1:0] LAST_COL = 2'(N_COLS - 1);

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, b_q, c_q;
  logic [1:0]     col_q;
  logic           accept;
  logic           col_done;

  assign accept   = in_valid & in_ready;
  assign col_done = (state_q == ROW2) & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-decoded handshake/tag outputs.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    out_valid = 1'b0;
    out_sel  = SEL_NONE;
    out_last = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ROW0;
      end
      ROW0: begin
        out_valid = 1'b1;
        out_sel   = SEL_ROW0;
        if (out_ready) state_d = ROW1;
      end
      ROW1: begin
        out_valid = 1'b1;
        out_sel   = SEL_ROW1;
        if (out_ready) state_d = ROW2;
      end
      ROW2: begin
        out_valid = 1'b1;
        out_sel   = SEL_ROW2;
        out_last  = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = in_valid ? ROW0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Column holding registers load only on accept, so the payload is frozen
  // for the whole column regardless of what the source does afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else if (accept) begin
      a_q <= in_a;
      b_q <= in_b;
      c_q <= in_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
    end else if (col_done) begin
      col_q <= (col_q == LAST_COL) ? 2'd0 : col_q + 2'd1;
    end
  end

  assign out_col       = col_q;
  assign out_frame_end = out_last & (col_q == LAST_COL);

  mux3x1 #(.W(W)) u_mux (
    .a   (a_q),
    .b   (b_q),
    .c   (c_q),
    .sel (out_sel),
    .y   (out_data)
  );

endmodule

// File: tb/tb_operand_sequencer.sv
// Scenario bench for operand_sequencer: directed cases plus a randomized run
// scored against a queue-based model of the serialized element stream.
module tb_operand_sequencer;

  localparam int unsigned INT_L  = 5;
  localparam int unsigned FRAC_L = 12;
  localparam int unsigned W      = INT_L + FRAC_L;
  localparam int unsigned NC     = 3;
  localparam int unsigned VW     = W + 8;

  logic         clk, rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_a, in_b, in_c, out_data;
  logic [1:0]   out_sel, out_col;
  logic         out_last, out_frame_end;

  int vectors = 0;
  int errors  = 0;

  logic [VW-1:0] obs;
  assign obs = {out_valid, out_sel, out_data, out_last, out_col, out_frame_end, in_ready};

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   sel;
    logic         last;
    logic [1:0]   col;
    logic         fe;
  } beat_t;

  operand_sequencer #(
    .INT_LENGTH (INT_L),
    .FRAC_LENGTH(FRAC_L),
    .N_COLS     (NC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_c         (in_c),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_sel      (out_sel),
    .out_last     (out_last),
    .out_col      (out_col),
    .out_frame_end(out_frame_end)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [VW-1:0] ev(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                                       input logic l, input logic [1:0] c, input logic f,
                                       input logic r);
    return {v, s, d, l, c, f, r};
  endfunction

  function automatic logic [VW-1:0] idle_vec(input logic [1:0] c);
    return ev(1'b0, 2'b11, '0, 1'b0, c, 1'b0, 1'b1);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_c = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [VW-1:0] e;
    e = idle_vec(2'd0);
    #2;
    vectors++;
    if (obs !== e) begin errors++; $display("FAIL reset_async got=%h exp=%h", obs, e); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (obs !== e) begin errors++; $display("FAIL reset_release got=%h exp=%h", obs, e); end
  endtask

  task automatic test_single_column();
    logic [VW-1:0] exp_s [5];
    exp_s[0] = idle_vec(2'd0);
    exp_s[1] = ev(1'b1, 2'b00, 17'h00100, 1'b0, 2'd0, 1'b0, 1'b0);
    exp_s[2] = ev(1'b1, 2'b01, 17'h1F000, 1'b0, 2'd0, 1'b0, 1'b0);
    exp_s[3] = ev(1'b1, 2'b10, 17'h0FFFF, 1'b1, 2'd0, 1'b0, 1'b1);
    exp_s[4] = idle_vec(2'd1);
    do_reset();
    in_valid = 1'b1; in_a = 17'h00100; in_b = 17'h1F000; in_c = 17'h0FFFF;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) in_valid = 1'b0;
      #1;
      vectors++;
      if (obs !== exp_s[i]) begin
        errors++; $display("FAIL single_col step=%0d got=%h exp=%h", i, obs, exp_s[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, c;
    logic [VW-1:0] e;
    a = W'($urandom); b = W'($urandom); c = W'($urandom);
    do_reset();
    in_valid = 1'b1; in_a = a; in_b = b; in_c = c;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_a = ~a; in_b = ~b; in_c = ~c;
    e = ev(1'b1, 2'b01, b, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (obs !== e) begin errors++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", i, obs, e); end
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    #1;
    vectors++;
    if (obs !== e) begin errors++; $display("FAIL bp_release got=%h exp=%h", obs, e); end
    @(negedge clk);
    #1;
    e = ev(1'b1, 2'b10, c, 1'b1, 2'd0, 1'b0, 1'b1);
    vectors++;
    if (obs !== e) begin errors++; $display("FAIL bp_row2 got=%h exp=%h", obs, e); end
    @(negedge clk);
    #1;
    vectors++;
    if (obs !== idle_vec(2'd1)) begin
      errors++; $display("FAIL bp_idle got=%h exp=%h", obs, idle_vec(2'd1));
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] trip [6][3];
    logic [VW-1:0] e;
    int n, k, r;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 3; j++) trip[i][j] = W'($urandom);
    do_reset();
    for (int t = 0; t < 20; t++) begin
      if (t > 0) @(negedge clk);
      k = t / 3;
      in_valid = (k < 6);
      if (k < 6) begin
        in_a = trip[k][0]; in_b = trip[k][1]; in_c = trip[k][2];
      end
      if (t == 0) e = idle_vec(2'd0);
      else if (t == 19) e = idle_vec(2'd0);
      else begin
        n = t - 1;
        r = n % 3;
        e = ev(1'b1, 2'(r), trip[n / 3][r], r == 2, 2'((n / 3) % 3),
               (r == 2) && ((n / 3) % 3 == 2), r == 2);
      end
      #1;
      vectors++;
      if (obs !== e) begin errors++; $display("FAIL b2b t=%0d got=%h exp=%h", t, obs, e); end
    end
  endtask

  task automatic test_input_change();
    logic [W-1:0] a, b, c;
    logic [VW-1:0] e;
    a = W'($urandom); b = W'($urandom); c = W'($urandom);
    do_reset();
    in_valid = 1'b1; in_a = a; in_b = b; in_c = c;
    @(negedge clk);
    in_valid = 1'b0; in_a = ~a; in_b = b ^ 17'h15555;
    #1;
    e = ev(1'b1, 2'b00, a, 1'b0, 2'd0, 1'b0, 1'b0);
    vectors++;
    if (obs !== e) begin errors++; $display("FAIL in_change_row0 got=%h exp=%h", obs, e); end
    @(negedge clk);
    #1;
    e = ev(1'b1, 2'b01, b, 1'b0, 2'd0, 1'b0, 1'b0);
    vectors++;
    if (obs !== e) begin errors++; $display("FAIL in_change_row1 got=%h exp=%h", obs, e); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] b;
    logic [VW-1:0] e;
    do_reset();
    in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom); in_c = W'($urandom);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (obs !== idle_vec(2'd1)) begin
      errors++; $display("FAIL rm_col1 got=%h exp=%h", obs, idle_vec(2'd1));
    end
    b = W'($urandom);
    in_valid = 1'b1; in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    e = ev(1'b1, 2'b01, b, 1'b0, 2'd1, 1'b0, 1'b0);
    vectors++;
    if (obs !== e) begin errors++; $display("FAIL rm_row1 got=%h exp=%h", obs, e); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== idle_vec(2'd0)) begin
      errors++; $display("FAIL rm_async got=%h exp=%h", obs, idle_vec(2'd0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (obs !== idle_vec(2'd0)) begin
        errors++; $display("FAIL rm_after cyc=%0d got=%h exp=%h", i, obs, idle_vec(2'd0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'($urandom);
      in_a = W'($urandom); in_b = W'($urandom); in_c = W'($urandom);
      #1;
      vectors++;
      if (obs !== idle_vec(2'd0)) begin
        errors++; $display("FAIL idle cyc=%0d got=%h exp=%h", i, obs, idle_vec(2'd0));
      end
      @(negedge clk);
    end
  endtask

  // Model: a queue of pending output elements; each accepted column appends
  // three tagged elements, each output handshake retires the head.
  task automatic test_random();
    beat_t q[$];
    beat_t bt;
    int accepted, completed;
    logic exp_rdy, exp_vld;
    logic [VW-1:0] e;
    logic [W-1:0] ta, tb, tc;
    accepted = 0; completed = 0;
    do_reset();
    for (int t = 0; t < 500; t++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ta = W'($urandom); tb = W'($urandom); tc = W'($urandom);
      in_a = ta; in_b = tb; in_c = tc;
      exp_vld = (q.size() != 0);
      exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
      if (exp_vld)
        e = ev(1'b1, q[0].sel, q[0].data, q[0].last, q[0].col, q[0].fe, exp_rdy);
      else
        e = idle_vec(2'(completed % NC));
      #1;
      vectors++;
      if (obs !== e) begin errors++; $display("FAIL random t=%0d got=%h exp=%h", t, obs, e); end
      if (exp_vld && out_ready) begin
        bt = q.pop_front();
        if (bt.last) completed++;
      end
      if (in_valid && exp_rdy) begin
        for (int r = 0; r < 3; r++) begin
          bt.data = (r == 0) ? ta : (r == 1) ? tb : tc;
          bt.sel  = 2'(r);
          bt.last = (r == 2);
          bt.col  = 2'(accepted % NC);
          bt.fe   = (r == 2) && (accepted % NC == NC - 1);
          q.push_back(bt);
        end
        accepted++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_c = '0;
    test_reset();
    test_single_column();
    test_backpressure();
    test_back_to_back();
    test_input_change();
    test_reset_mid();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter INT_LENGTH, default 5, integer bits of the fixed-point word.
REQ-002 SHALL have parameter FRAC_LENGTH, default 12, fraction bits; word width W = INT_LENGTH+FRAC_LENGTH.
REQ-003 SHALL have parameter N_COLS, default 3, number of matrix columns per frame (range 2..4).
REQ-004 SHALL have the port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-005 SHALL have the port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-006 SHALL have the port in_valid, input, 1 bit, meaning a column triple is offered.
REQ-007 SHALL have the port in_ready, output, 1 bit, meaning the block accepts a triple this cycle.
REQ-008 SHALL have the ports in_a, in_b, in_c, input, W bits each, holding column elements rows 0, 1 and 2 (signed fixed-point).
REQ-009 SHALL have the port out_valid, output, 1 bit, meaning out_data is valid.
REQ-010 SHALL have the port out_ready, input, 1 bit, meaning downstream accepts out_data.
REQ-011 SHALL have the port out_data, output, W bits, the current serialized element.
REQ-012 SHALL have the port out_sel, output, 2 bits, giving the row index of out_data (2'b11 = none).
REQ-013 SHALL have the port out_last, output, 1 bit, marking row 2 of a column.
REQ-014 SHALL have the port out_col, output, 2 bits, giving the column index within the frame.
REQ-015 SHALL have the port out_frame_end, output, 1 bit, marking row 2 of column N_COLS-1.

Function
REQ-016 SHALL implement the FSM states IDLE, ROW0, ROW1 and ROW2.
REQ-017 SHALL drive in_ready = 1 in IDLE, 1 in ROW2 when out_ready=1, and 0 otherwise.
REQ-018 SHALL capture in_a/in_b/in_c into holding registers on the accept condition (in_valid & in_ready); the next state is ROW0.
REQ-019 SHALL transition ROW0->ROW1 and ROW1->ROW2 only on the handshake (out_valid & out_ready); otherwise the state holds.
REQ-020 SHALL, in ROW2 on handshake, go to ROW0 if in_valid=1 (back-to-back, no bubble) and to IDLE otherwise.
REQ-021 SHALL drive out_valid = 1 in ROW0..ROW2 and 0 in IDLE.
REQ-022 SHALL drive out_sel = 00/01/10 in ROW0/ROW1/ROW2 respectively and 11 in IDLE.
REQ-023 SHALL make out_data the mux of the holding registers by out_sel, with 0 when out_sel = 11.
REQ-024 SHALL hold out_data, out_sel and out_col stable while out_valid=1 and out_ready=0.
REQ-025 SHALL keep the holding registers unchanged while the block is in ROW0..ROW1 or stalled in ROW2.
REQ-026 SHALL drive out_last = 1 only in ROW2.
REQ-027 SHALL increment the column counter on the ROW2 handshake, wrapping N_COLS-1 -> 0.
REQ-028 SHALL assert out_frame_end when out_last=1 and out_col = N_COLS-1.
REQ-029 SHALL give a latency from input accept to the first out_valid of 1 cycle.
REQ-030 SHALL give a sustained throughput of 1 element/cycle when out_ready=1 and the input is always valid.
REQ-031 SHALL have no combinational path from in_a/in_b/in_c to any output.
REQ-032 SHALL not depend on in_valid being held after acceptance.

Reset
REQ-033 SHALL, while rst_n=0, force state=IDLE, holding registers=0 and column counter=0, independent of clk.
REQ-034 SHALL give the output values out_valid=0, out_sel=11, out_data=0, out_last=0, out_col=0, out_frame_end=0 and in_ready=1 after reset.
REQ-035 SHALL abort an in-flight column on reset mid-operation with no partial output afterwards.

Structure
REQ-036 SHALL define the FSM state encoding, the SEL_NONE=2'b11 constant and the default INT_LENGTH/FRAC_LENGTH in the shared fixed-point package.
REQ-037 SHALL instantiate the existing mux3x1 as the one sub-module for out_data selection, driven by out_sel.

Verification
REQ-038 SHALL cover single column: in a/b/c = 0x00100/0x1F000/0x0FFFF with out_ready=1 -> out_data 0x00100, 0x1F000, 0x0FFFF on cycles 1..3; out_sel 0,1,2; out_last only on the 3rd.
REQ-039 SHALL cover backpressure: out_ready=0 for 4 cycles in ROW1 -> out_data=b and out_sel=01 held, in_ready=0, then ROW2 on release.
REQ-040 SHALL cover back-to-back: 6 columns with in_valid=1 continuously -> 18 consecutive valid beats, no bubble, out_col 0,1,2,0,1,2, out_frame_end on beats 9 and 18.
REQ-041 SHALL cover input change after accept: in_a is altered the cycle after accept -> the emitted row0 equals the originally captured value.
REQ-042 SHALL cover reset mid-operation: rst_n low asynchronously during ROW1 -> out_valid=0 and out_sel=11 immediately, out_col=0, in_ready=1 after release.
REQ-043 SHALL cover idle: no input for 10 cycles -> out_valid=0, out_data=0, out_sel=11 throughout.
